ammo_manager: RTL and testbench

//  Parametrised per-player ammunition controller for the firing path: tracks shots

---
 rtl/ammo_manager.sv | 140 ++++++++++++++
 tb/tb_ammo_manager.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ammo_manager.sv
// Per-player ammunition controller: shot count, post-shot cooldown,
// timed shell-by-shell reload and dry-fire reporting.
module ammo_manager #(
  parameter int MAX_SHOTS       = 3,
  parameter int COOLDOWN_CYCLES = 4,
  parameter int RELOAD_CYCLES   = 8,
  parameter int SHOT_W          = $clog2(MAX_SHOTS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fire,
  input  logic              reload_req,
  input  logic              round_start,
  output logic [SHOT_W-1:0] remaining_shots,
  output logic              shot_fired,
  output logic              dry_fire,
  output logic              reloading,
  output logic              empty,
  output logic              can_fire
);

  localparam int TMAX = (COOLDOWN_CYCLES > RELOAD_CYCLES) ?
                        COOLDOWN_CYCLES : RELOAD_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] CD_INIT =
    TW'((COOLDOWN_CYCLES > 0) ? COOLDOWN_CYCLES - 1 : 0);
  localparam logic [TW-1:0] RL_INIT = TW'(RELOAD_CYCLES - 1);
  localparam logic [SHOT_W-1:0] FULL = SHOT_W'(MAX_SHOTS);
  localparam logic [SHOT_W-1:0] ONE  = SHOT_W'(1);

  typedef enum logic [1:0] {
    READY    = 2'd0,
    COOLDOWN = 2'd1,
    RELOAD   = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [TW-1:0]     timer, timer_n;
  logic [SHOT_W-1:0] rem, rem_n;
  logic              sf_n, df_n;
  logic              has_ammo;

  assign has_ammo = (rem != '0);

  // State, timer, count and pulse registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= READY;
      timer      <= '0;
      rem        <= FULL;
      shot_fired <= 1'b0;
      dry_fire   <= 1'b0;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      rem        <= rem_n;
      shot_fired <= sf_n;
      dry_fire   <= df_n;
    end
  end

  // Next-state: round_start beats fire, fire beats reload_req
  always_comb begin
    state_n = state;
    timer_n = timer;
    rem_n   = rem;
    sf_n    = 1'b0;
    df_n    = 1'b0;
    if (round_start) begin
      state_n = READY;
      timer_n = '0;
      rem_n   = FULL;
    end else begin
      unique case (state)
        READY: begin
          if (fire) begin
            if (has_ammo) begin
              rem_n = rem - ONE;
              sf_n  = 1'b1;
              if (COOLDOWN_CYCLES > 0) begin
                state_n = COOLDOWN;
                timer_n = CD_INIT;
              end
            end else begin
              df_n = 1'b1;
            end
          end else if (reload_req && rem != FULL) begin
            state_n = RELOAD;
            timer_n = RL_INIT;
          end
        end
        COOLDOWN: begin
          if (timer == '0) begin
            state_n = READY;
          end else begin
            timer_n = timer - 1'b1;
          end
        end
        RELOAD: begin
          if (fire && has_ammo) begin
            rem_n = rem - ONE;
            sf_n  = 1'b1;
            if (COOLDOWN_CYCLES > 0) begin
              state_n = COOLDOWN;
              timer_n = CD_INIT;
            end else begin
              state_n = READY;
              timer_n = '0;
            end
          end else begin
            df_n = fire;
            if (timer == '0) begin
              rem_n = rem + ONE;
              if (rem_n == FULL) begin
                state_n = READY;
                timer_n = '0;
              end else begin
                timer_n = RL_INIT;
              end
            end else begin
              timer_n = timer - 1'b1;
            end
          end
        end
        default: begin
          state_n = READY;
          timer_n = '0;
        end
      endcase
    end
  end

  assign remaining_shots = rem;
  assign reloading       = (state == RELOAD);
  assign empty           = !has_ammo;
  assign can_fire        = has_ammo &&
                           (state == READY || state == RELOAD);

endmodule

// File: tb/tb_ammo_manager.sv
// Directed bench for ammo_manager with a cycle-level behavioural
// model compared on every falling edge plus literal spot checks.
module tb_ammo_manager;

  localparam int MS = 3;
  localparam int CC = 4;
  localparam int RC = 8;
  localparam int SW = $clog2(MS + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          fire = 1'b0;
  logic          reload_req = 1'b0;
  logic          round_start = 1'b0;
  logic [SW-1:0] remaining_shots;
  logic          shot_fired, dry_fire, reloading, empty, can_fire;

  int checks = 0;
  int errors = 0;

  ammo_manager #(
    .MAX_SHOTS(MS), .COOLDOWN_CYCLES(CC), .RELOAD_CYCLES(RC)
  ) dut (
    .clk(clk), .reset(reset), .fire(fire),
    .reload_req(reload_req), .round_start(round_start),
    .remaining_shots(remaining_shots), .shot_fired(shot_fired),
    .dry_fire(dry_fire), .reloading(reloading),
    .empty(empty), .can_fire(can_fire)
  );

  always #5 clk = ~clk;

  // model: cd = edges still to be ignored after a shot,
  // prog = edges elapsed in the current shell
  int m_rem = MS;
  int m_cd = 0;
  int m_prog = 0;
  bit m_rl = 0;
  bit m_sf = 0;
  bit m_df = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_rem = MS; m_cd = 0; m_prog = 0;
      m_rl = 0; m_sf = 0; m_df = 0;
    end else begin
      bit started;
      started = 0;
      m_sf = 0; m_df = 0;
      if (round_start) begin
        m_rem = MS; m_cd = 0; m_rl = 0; m_prog = 0;
      end else if (m_cd > 0) begin
        m_cd = m_cd - 1;
      end else begin
        if (fire) begin
          if (m_rem > 0) begin
            m_rem = m_rem - 1; m_sf = 1; m_rl = 0; m_cd = CC;
          end else begin
            m_df = 1;
          end
        end else if (reload_req && !m_rl && m_rem < MS) begin
          m_rl = 1; m_prog = 0; started = 1;
        end
        if (m_rl && !started) begin
          m_prog = m_prog + 1;
          if (m_prog == RC) begin
            m_rem = m_rem + 1; m_prog = 0;
            if (m_rem == MS) m_rl = 0;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // compare all outputs against the model every cycle
  always @(negedge clk) begin
    if (!reset) begin
      bit cf;
      cf = (m_rem > 0) && (m_cd == 0);
      chk("model.remaining", int'(remaining_shots), m_rem);
      chk("model.shot_fired", int'(shot_fired), int'(m_sf));
      chk("model.dry_fire", int'(dry_fire), int'(m_df));
      chk("model.reloading", int'(reloading), int'(m_rl));
      chk("model.empty", int'(empty), int'(m_rem == 0));
      chk("model.can_fire", int'(can_fire), int'(cf));
    end
  end

  task automatic cyc(input bit f, input bit r, input bit rs);
    fire = f; reload_req = r; round_start = rs;
    @(posedge clk);
    @(negedge clk);
    fire = 0; reload_req = 0; round_start = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst.remaining", int'(remaining_shots), 3);
    chk("rst.reloading", int'(reloading), 0);
    chk("rst.pulses", int'(shot_fired | dry_fire), 0);
    reset = 0;
    @(negedge clk);

    // 1: cooldown holds off a held trigger
    cyc(1, 0, 0);
    chk("t1.shot", int'(shot_fired), 1);
    chk("t1.rem2", int'(remaining_shots), 2);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0);
    chk("t1.held_ignored", int'(remaining_shots), 2);
    cyc(1, 0, 0);
    chk("t1.rem1", int'(remaining_shots), 1);

    // 2: empty then dry fire
    idle(4);
    cyc(1, 0, 0);
    idle(4);
    chk("t2.rem0", int'(remaining_shots), 0);
    chk("t2.empty", int'(empty), 1);
    chk("t2.can_fire", int'(can_fire), 0);
    cyc(1, 0, 0);
    chk("t2.dry", int'(dry_fire), 1);
    chk("t2.rem_stays", int'(remaining_shots), 0);

    // 3: full reload from empty
    cyc(0, 1, 0);
    chk("t3.reloading", int'(reloading), 1);
    idle(7);
    chk("t3.before8", int'(remaining_shots), 0);
    idle(1);
    chk("t3.at8", int'(remaining_shots), 1);
    idle(8);
    chk("t3.at16", int'(remaining_shots), 2);
    idle(8);
    chk("t3.at24", int'(remaining_shots), 3);
    chk("t3.done", int'(reloading), 0);
    cyc(0, 1, 0);
    chk("t3.full_ignored", int'(reloading), 0);

    // 4: fire aborts a reload
    cyc(1, 0, 0); idle(4); cyc(1, 0, 0); idle(4);
    cyc(0, 1, 0);
    idle(2);
    cyc(1, 0, 0);
    chk("t4.reloading", int'(reloading), 0);
    chk("t4.rem", int'(remaining_shots), 0);
    chk("t4.shot", int'(shot_fired), 1);
    chk("t4.cooldown", int'(can_fire), 0);

    // 5: round_start beats fire in cooldown
    cyc(1, 0, 1);
    chk("t5.rem", int'(remaining_shots), 3);
    chk("t5.no_pulse", int'(shot_fired | dry_fire), 0);
    cyc(1, 0, 0);
    chk("t5.ready_shot", int'(shot_fired), 1);

    // dry fire mid-reload keeps the reload going
    idle(4); cyc(1, 0, 0); idle(4); cyc(1, 0, 0); idle(4);
    cyc(0, 1, 0);
    idle(3);
    cyc(1, 0, 0);
    chk("dry_in_reload", int'(dry_fire), 1);
    idle(4);
    chk("reload_survives", int'(remaining_shots), 1);

    // 6: async reset mid-reload
    idle(3);
    #2 reset = 1;
    #1;
    chk("t6.rem", int'(remaining_shots), 3);
    chk("t6.reloading", int'(reloading), 0);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    cyc(1, 0, 0);
    chk("t6.after", int'(remaining_shots), 2);
    idle(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
